// File: rtl/neuron_feeder.sv
// Sequencer that buffers one activation vector, steps a single MAC/ReLU neuron
// through clear, N_IN MAC steps and one bias step, then offers the result downstream.
module neuron_feeder #(
    parameter int N_IN = 8,
    parameter int AW   = $clog2(N_IN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [15:0]   in_data,
    output logic          in_ready,
    input  logic          w_we,
    input  logic [AW-1:0] w_addr,
    input  logic [15:0]   w_data,
    input  logic          bias_we,
    input  logic [15:0]   bias_data,
    output logic          nrn_rst,
    output logic          nrn_en,
    output logic          nrn_mac,
    output logic [15:0]   nrn_in,
    output logic [15:0]   nrn_wgh,
    output logic [15:0]   nrn_bias,
    input  logic [15:0]   nrn_out,
    output logic          out_valid,
    output logic [15:0]   out_data,
    input  logic          out_ready,
    output logic          busy
);

    typedef enum logic [2:0] {
        S_LOAD,
        S_CLR,
        S_MAC,
        S_BIAS,
        S_CAP,
        S_OUT
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(N_IN - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [15:0]   out_data_q, out_data_d;

    logic [15:0]   inbuf_q [N_IN];
    logic [15:0]   wmem_q  [N_IN];
    logic [15:0]   bias_q;

    logic          in_hs;
    logic          cfg_wr_ok;
    logic          clr_phase;

    assign in_hs     = in_valid && (state_q == S_LOAD);
    // Configuration writes land only while the neuron is not consuming them.
    assign cfg_wr_ok = (state_q == S_LOAD) || (state_q == S_OUT);

    // Buffers carry no reset: contents are only meaningful once written.
    genvar gi;
    for (gi = 0; gi < N_IN; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (in_hs && (cnt_q == AW'(gi))) begin
                inbuf_q[gi] <= in_data;
            end
            if (w_we && cfg_wr_ok && (w_addr == AW'(gi))) begin
                wmem_q[gi] <= w_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (bias_we && cfg_wr_ok) begin
            bias_q <= bias_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_LOAD;
            cnt_q      <= '0;
            idx_q      <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            out_data_q <= out_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        out_data_d = out_data_q;
        in_ready   = 1'b0;
        clr_phase  = 1'b0;
        nrn_en     = 1'b0;
        nrn_mac    = 1'b0;
        nrn_in     = '0;
        nrn_wgh    = '0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state_q)
            S_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = S_CLR;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_CLR: begin
                clr_phase = 1'b1;
                idx_d     = '0;
                state_d   = S_MAC;
            end
            S_MAC: begin
                nrn_en  = 1'b1;
                nrn_in  = inbuf_q[idx_q];
                nrn_wgh = wmem_q[idx_q];
                if (idx_q == LAST) begin
                    idx_d   = '0;
                    state_d = S_BIAS;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_BIAS: begin
                nrn_en  = 1'b1;
                nrn_mac = 1'b1;
                state_d = S_CAP;
            end
            S_CAP: begin
                // Neuron result registered at the end of BIAS is stable here.
                out_data_d = nrn_out;
                state_d    = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_LOAD;
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    assign nrn_rst  = !rst || clr_phase;
    assign nrn_bias = bias_q;
    assign out_data = out_data_q;

endmodule
